// File: rtl/digital_dart_game.sv
// Five-player, three-round dart game: LFSR-driven dart values, per-player
// saturating totals, and winner selection when the 15th throw lands.
module digital_dart_game (
    input  logic       clk,
    input  logic       reset,
    input  logic       throw_button,
    output logic [2:0] player_id,
    output logic [4:0] score_display,
    output logic [4:0] final_score
);

    // state | meaning
    // PLAY  | accepting throws, player_id is the player on turn
    // DONE  | game over, player_id/final_score hold the winner until reset
    typedef enum logic {PLAY, DONE} state_t;

    state_t     state_q;
    logic [7:0] lfsr_q;
    logic       btn_q;
    logic [4:0] total_q [5];
    logic [2:0] player_q;
    logic [1:0] round_q;
    logic [4:0] score_q;
    logic [4:0] final_q;

    logic       throw_d;
    logic       last_throw_d;
    logic [3:0] nib_d;
    logic [3:0] dart_d;
    logic [5:0] sum_d;
    logic [4:0] total_new_d;
    logic [4:0] totals_d [5];
    logic [4:0] best_val_d;
    logic [2:0] best_id_d;
    logic [7:0] lfsr_next_d;

    assign throw_d      = (state_q == PLAY) && throw_button && !btn_q;
    assign last_throw_d = (player_q == 3'd4) && (round_q == 2'd2);
    assign nib_d        = lfsr_q[3:0];
    assign dart_d       = (nib_d <= 4'd10) ? nib_d : nib_d - 4'd11;
    assign sum_d        = {1'b0, total_q[player_q]} + {2'b00, dart_d};
    assign total_new_d  = (sum_d > 6'd31) ? 5'd31 : sum_d[4:0];
    assign lfsr_next_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Winner is taken over the totals including the throw being accepted now,
    // scanning upward with strict compare so ties resolve to the lowest id.
    always_comb begin
        best_val_d = 5'd0;
        best_id_d  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            totals_d[i] = (3'(i) == player_q) ? total_new_d : total_q[i];
        end
        best_val_d = totals_d[0];
        for (int i = 1; i < 5; i++) begin
            if (totals_d[i] > best_val_d) begin
                best_val_d = totals_d[i];
                best_id_d  = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= PLAY;
            lfsr_q   <= 8'hA5;
            btn_q    <= 1'b0;
            player_q <= 3'd0;
            round_q  <= 2'd0;
            score_q  <= 5'd0;
            final_q  <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                total_q[i] <= 5'd0;
            end
        end else begin
            btn_q <= throw_button;
            if (throw_d) begin
                lfsr_q  <= lfsr_next_d;
                score_q <= total_new_d;
                for (int i = 0; i < 5; i++) begin
                    total_q[i] <= totals_d[i];
                end
                if (last_throw_d) begin
                    state_q  <= DONE;
                    player_q <= best_id_d;
                    final_q  <= best_val_d;
                end else if (player_q == 3'd4) begin
                    player_q <= 3'd0;
                    round_q  <= round_q + 2'd1;
                end else begin
                    player_q <= player_q + 3'd1;
                end
            end
        end
    end

    assign player_id     = player_q;
    assign score_display = score_q;
    assign final_score   = final_q;

endmodule

// File: tb/tb_digital_dart_game.sv
// Bench for digital_dart_game: randomized throw timing, a game-level reference
// model, and a queue scoreboard drained by an independent monitor.
module tb_digital_dart_game;

    logic       clk;
    logic       reset;
    logic       throw_button;
    logic [2:0] player_id;
    logic [4:0] score_display;
    logic [4:0] final_score;

    digital_dart_game dut (
        .clk           (clk),
        .reset         (reset),
        .throw_button  (throw_button),
        .player_id     (player_id),
        .score_display (score_display),
        .final_score   (final_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int          pid;
        int          disp;
        int          fin;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // game-level reference: throw count decides player and round
    logic [7:0] m_lfsr;
    int         m_tot [5];
    int         m_cnt;
    int         m_pid, m_disp, m_fin;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_lfsr = 8'hA5;
        for (int i = 0; i < 5; i++) m_tot[i] = 0;
        m_cnt  = 0;
        m_pid  = 0;
        m_disp = 0;
        m_fin  = 0;
    endtask

    task automatic m_throw();
        int n, v, p, best;
        if (m_cnt >= 15) return;
        n = int'(m_lfsr[3:0]);
        v = (n <= 10) ? n : n - 11;
        p = m_cnt % 5;
        m_tot[p] = (m_tot[p] + v > 31) ? 31 : m_tot[p] + v;
        m_disp = m_tot[p];
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_cnt++;
        if (m_cnt == 15) begin
            best = 0;
            for (int i = 1; i < 5; i++) if (m_tot[i] > m_tot[best]) best = i;
            m_fin = m_tot[best];
            m_pid = best;
        end else begin
            m_pid = m_cnt % 5;
        end
    endtask

    // push the model's view for the coming edge, then advance to the next negedge
    task automatic tick();
        exp_t e;
        e.cyc  = cyc + 1;
        e.pid  = m_pid;
        e.disp = m_disp;
        e.fin  = m_fin;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse(int w, int g);
        throw_button = 1'b1;
        m_throw();
        tick();
        repeat (w - 1) tick();
        throw_button = 1'b0;
        repeat (g) tick();
    endtask

    // asserts reset off the clock edge, checks the async clear, releases at a negedge
    task automatic do_reset();
        #2 reset = 1'b0;
        m_reset();
        #1;
        chk("rst_pid",   int'(player_id),     0);
        chk("rst_disp",  int'(score_display), 0);
        chk("rst_final", int'(final_score),   0);
        @(negedge clk);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("sb_pid",   int'(player_id),     e.pid);
                chk("sb_disp",  int'(score_display), e.disp);
                chk("sb_final", int'(final_score),   e.fin);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        throw_button = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("init_pid",   int'(player_id),     0);
        chk("init_disp",  int'(score_display), 0);
        chk("init_final", int'(final_score),   0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        pulse(1, 2);
        chk("t1_disp", int'(score_display), 5);
        chk("t1_pid",  int'(player_id),     1);
        pulse(1, 1);
        chk("t2_disp", int'(score_display), 10);
        chk("t2_pid",  int'(player_id),     2);

        pulse(10, 2);
        chk("hold_pid", int'(player_id), 3);

        for (int i = 4; i <= 15; i++) pulse($urandom_range(1, 3), $urandom_range(1, 3));
        chk("game1_final", int'(final_score), m_fin);
        chk("game1_winner", int'(player_id),  m_pid);
        pulse(2, 2);
        pulse(1, 1);

        do_reset();
        tick();
        for (int i = 0; i < 7; i++) pulse($urandom_range(1, 2), $urandom_range(1, 4));
        do_reset();
        tick();
        pulse(1, 1);
        chk("after_rst_disp", int'(score_display), 5);
        chk("after_rst_pid",  int'(player_id),     1);

        throw_button = 1'b1;
        do_reset();
        m_throw();
        tick();
        throw_button = 1'b0;
        tick();
        chk("held_rst_disp", int'(score_display), 5);

        for (int g = 0; g < 3; g++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) tick();
            for (int i = 0; i < 17; i++) pulse($urandom_range(1, 4), $urandom_range(1, 3));
            chk("gameN_final", int'(final_score), m_fin);
        end

        repeat (3) tick();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digital_dart_game.md
DIGITAL_DART_GAME -- requirements
Module: digital_dart_game

Interface
REQ-001 The module SHALL have exactly these ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- throw_button  input  1  dart-throw request, level input, edge-detected internally.
- player_id  output  3  during play: player whose turn it is (0..4); after game over: winner id.
- score_display  output  5  accumulated total of the player who made the most recent accepted throw.
- final_score  output  5  winning total after game over; 0 while the game is in progress.

REQ-002 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Function
REQ-003 The game SHALL have 5 players (ids 0..4) and 3 rounds; each player makes one throw per round, 15 accepted throws total.
REQ-004 A throw SHALL be accepted on a rising clk edge where throw_button=1 and the internally registered previous sample of throw_button=0; holding the button high SHALL yield exactly one throw.
REQ-005 Dart values SHALL come from an 8-bit Fibonacci LFSR: seed 8'hA5 at reset; next state = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-006 The LFSR SHALL advance only on accepted throws, so the value sequence is independent of throw timing.
REQ-007 Dart value SHALL be computed from the current LFSR state before stepping: n=lfsr[3:0]; value = n if n<=10, else n-11, giving a range of 0..10.
REQ-008 On an accepted throw, the current player's 5-bit total SHALL add the dart value, saturating at 31 (no wrap).
REQ-009 On an accepted throw, score_display SHALL update at the same edge to the thrower's new total.
REQ-010 On an accepted throw, player_id SHALL advance 0→1→2→3→4→0; the round counter (0..2) SHALL increment when player 4 throws.
REQ-011 The FSM SHALL have two states, PLAY and DONE; reset enters PLAY.
REQ-012 PLAY SHALL transition to DONE on the edge that accepts player 4's throw in round 2, the 15th throw.
REQ-013 On entering DONE, at the same edge:
- final_score SHALL become the maximum of the 5 totals.
- player_id SHALL become the winner's id; ties go to the lowest id.
- score_display SHALL hold player 4's final total.
REQ-014 In DONE, throw_button SHALL be ignored: no LFSR step and no change to any output until reset.
REQ-015 Throw latency SHALL be one clock: outputs reflect a throw at the edge that samples the button rising.

Reset
REQ-016 While reset=0:
- player_id=0, score_display=0, final_score=0.
- All 5 totals=0, round=0, LFSR=8'hA5, previous-button register=0, state=PLAY.
REQ-017 Asserting reset mid-game SHALL abort the game immediately (asynchronously) and discard all totals.
REQ-018 After reset deasserts, the first rising button edge SHALL be treated as throw 1, including when the button was already high during reset (the previous-sample register reads 0).

Verification
REQ-019 Reset value check: hold reset=0 for 2 cycles → player_id=0, score_display=0, final_score=0.
REQ-020 First two throws: throw 1 → score_display=5, player_id=1; throw 2 → score_display=10 (LFSR 8'h4A), player_id=2.
REQ-021 Hold throw_button high for 10 cycles → exactly one throw accepted; player_id advances by 1.
REQ-022 Full game: 15 separated pulses → DONE after the 15th pulse:
- final_score equals the maximum of a reference model's totals, and player_id equals that model's winner id.
- A 16th pulse changes nothing.
REQ-023 Reset mid-game: assert reset after throw 7 → all outputs 0 immediately; the next throw yields score_display=5 again.
REQ-024 Saturation: force the LFSR seed or a model with a high-value sequence → a total never exceeds 31.
